adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter NREQ, default 3, number of requesters (fixed 3 for ID encoding).
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester add request.
REQ-006 req_a  input  NREQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
REQ-007 req_b  input  NREQ*WIDTH  packed operand B, same packing.
REQ-008 req_ready  output  NREQ  one-hot grant; at most one bit high per cycle.
REQ-009 resp_valid  output  1  result register holds an unconsumed sum.
REQ-010 resp_id  output  2  index of the requester that owns resp_data.
REQ-011 resp_data  output  WIDTH  registered sum, a+b modulo 2^WIDTH.
REQ-012 resp_ready  input  1  consumer accepts the response this cycle.

Function
REQ-013 The block SHALL share one WIDTH-bit adder among NREQ requesters; a transfer occurs on a rising edge where req_valid[i] && req_ready[i].
REQ-014 FSM states SHALL be IDLE (result register empty) and HOLD (result register full).
REQ-015 In IDLE, req_ready SHALL be the round-robin winner among asserted req_valid; no valid -> req_ready all zero.
REQ-016 In HOLD with resp_ready=1, req_ready SHALL grant the round-robin winner (back-to-back issue, one sum per cycle sustained).
REQ-017 In HOLD with resp_ready=0, req_ready SHALL be all zero and resp_valid/resp_id/resp_data SHALL hold stable.
REQ-018 On a grant, the next edge SHALL load resp_data=req_a[i]+req_b[i] (carry-out discarded), resp_id=i, resp_valid=1, state=HOLD; latency grant-edge to resp_valid is 1 cycle.
REQ-019 HOLD, resp_ready=1, no grant -> next state IDLE, resp_valid=0; resp_data retains last value.
REQ-020 Round-robin: after granting i, priority order for the next grant SHALL be i+1, i+2, ... wrapping modulo NREQ; pointer unchanged when no grant.
REQ-021 req_ready SHALL be a combinational function of req_valid, state, resp_ready and pointer only (no dependency on operands).
REQ-022 A requester deasserting req_valid before grant SHALL lose its place without side effects.
REQ-023 Wrap-around: 32'hFFFFFFFF + 32'h00000001 SHALL yield 32'h00000000.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, resp_valid=0, resp_id=0, resp_data=0, pointer so requester 0 has highest priority, req_ready=0.
REQ-025 Reset asserted mid-HOLD SHALL discard the held result; no response emitted after release.
REQ-026 First grant possible in the first clk edge after rst_n deasserts.

Configuration
REQ-027 Macro ADDER_ARB_OVF_EN: when defined, output resp_ovf (1 bit) SHALL be registered with resp_data as signed two's-complement overflow (operands same sign, sum sign differs), reset 0, held under backpressure.
REQ-028 Without ADDER_ARB_OVF_EN, port resp_ovf SHALL NOT exist and no overflow logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-029 Req0 only, a=123, b=11 -> req_ready=3'b001 same cycle; next cycle resp_valid=1, resp_id=0, resp_data=134.
REQ-030 All three valid continuously, resp_ready=1 from reset -> grant sequence 0,1,2,0,1,2; one response per cycle, ids in same order.
REQ-031 Response pending, resp_ready=0 for 4 cycles with req1 valid -> req_ready=0, resp_data stable 4 cycles; req1 granted the cycle resp_ready rises.
REQ-032 Req2 a=32'hFFFFFFFF, b=1 -> resp_data=0; with ADDER_ARB_OVF_EN, a=32'h7FFFFFFF, b=1 -> resp_ovf=1, a=32'hFFFFFFFF, b=1 -> resp_ovf=0.
REQ-033 Assert rst_n low while resp_valid=1 (asynchronous, between edges) -> resp_valid, resp_data, req_ready drop to 0 immediately; after release req0 wins a 3-way tie.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters.
// Define ADDER_ARB_OVF_EN to add the registered signed-overflow flag resp_ovf.
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    resp_valid,
  output logic [1:0]              resp_id,
  output logic [WIDTH-1:0]        resp_data,
`ifdef ADDER_ARB_OVF_EN
  output logic                    resp_ovf,
`endif
  input  logic                    resp_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic             issue_en;
  logic [2:0]       cand;
  logic             win_any;
  logic [1:0]       win_id;
  logic [NREQ-1:0]  win_oh;
  logic             grant;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] sum;

  // A new sum may issue when the result register is empty or drains now.
  always_comb begin
    issue_en = (state == IDLE) || resp_ready;
  end

  always_comb begin
    cand    = '0;
    win_any = 1'b0;
    win_id  = '0;
    win_oh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      if (!win_any && req_valid[cand[1:0]]) begin
        win_any             = 1'b1;
        win_id              = cand[1:0];
        win_oh[cand[1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = (win_id == 2'(NREQ-1)) ? 2'd0 : win_id + 2'd1;
  end

  // Reset must hold the grant low even though the state already reads IDLE.
  always_comb begin
    grant     = rst_n && issue_en && win_any;
    req_ready = grant ? win_oh : '0;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
    sum = sel_a + sel_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      resp_id   <= '0;
      resp_data <= '0;
    end else if (grant) begin
      state     <= HOLD;
      ptr       <= ptr_nxt;
      resp_id   <= win_id;
      resp_data <= sum;
    end else if (resp_ready) begin
      state     <= IDLE;
    end
  end

  assign resp_valid = (state == HOLD);

`ifdef ADDER_ARB_OVF_EN
  logic ovf_nxt;

  always_comb begin
    ovf_nxt = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) &&
              (sum[WIDTH-1] != sel_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_ovf <= 1'b0;
    end else if (grant) begin
      resp_ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: reference model plus directed vectors.
// Define ADDER_ARB_OVF_EN to also cover resp_ovf.
module tb_adder_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req_valid;
  logic [W-1:0] a [3];
  logic [W-1:0] b [3];
  logic [3*W-1:0] req_a;
  logic [3*W-1:0] req_b;
  logic [2:0]   req_ready;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [W-1:0] resp_data;
  logic         resp_ready;
`ifdef ADDER_ARB_OVF_EN
  logic         resp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  assign req_a = {a[2], a[1], a[0]};
  assign req_b = {b[2], b[1], b[0]};

  adder_arbiter #(.WIDTH(W), .NREQ(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
`ifdef ADDER_ARB_OVF_EN
    .resp_ovf   (resp_ovf),
`endif
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: a result slot that is full or empty, and a "next in line" index.
  bit           m_full;
  int           m_ptr;
  int           m_id;
  logic [W-1:0] m_data;
  bit           m_ovf;

  function automatic int pick(input logic [2:0] v, input int p,
                              input bit full, input bit rr);
    if (full && !rr) return -1;
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  function automatic bit sovf(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = sx + sy;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_ptr  <= 0;
      m_id   <= 0;
      m_data <= '0;
      m_ovf  <= 1'b0;
    end else if (pick(req_valid, m_ptr, m_full, resp_ready) >= 0) begin
      m_full <= 1'b1;
      m_id   <= pick(req_valid, m_ptr, m_full, resp_ready);
      m_ptr  <= (pick(req_valid, m_ptr, m_full, resp_ready) + 1) % 3;
      m_data <= a[pick(req_valid, m_ptr, m_full, resp_ready)] +
                b[pick(req_valid, m_ptr, m_full, resp_ready)];
      m_ovf  <= sovf(a[pick(req_valid, m_ptr, m_full, resp_ready)],
                     b[pick(req_valid, m_ptr, m_full, resp_ready)]);
    end else if (resp_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [2:0] er;
    g  = pick(req_valid, m_ptr, m_full, resp_ready);
    er = (rst_n && g >= 0) ? 3'(1 << g) : 3'b000;
    chk("m_ready", 64'(req_ready), 64'(er));
    chk("m_valid", 64'(resp_valid), 64'(m_full));
    if (m_full) begin
      chk("m_id", 64'(resp_id), 64'(m_id));
      chk("m_data", 64'(resp_data), 64'(m_data));
`ifdef ADDER_ARB_OVF_EN
      chk("m_ovf", 64'(resp_ovf), 64'(m_ovf));
`endif
    end
  end

  task automatic to_drive();
    @(negedge clk);
    #2;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]   exp_g [6];
  logic [W-1:0] held;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    chk("rst_data", 64'(resp_data), 64'd0);
    repeat (2) @(posedge clk);

    // single request, first edge after reset release
    to_drive();
    rst_n      = 1'b1;
    a[0]       = 32'd123;
    b[0]       = 32'd11;
    req_valid  = 3'b001;
    resp_ready = 1'b1;
    #1;
    chk("r0_ready", 64'(req_ready), 64'b001);
    after_edge();
    chk("r0_valid", 64'(resp_valid), 64'd1);
    chk("r0_id", 64'(resp_id), 64'd0);
    chk("r0_data", 64'(resp_data), 64'd134);
    to_drive();
    req_valid = '0;

    // three-way contention from a fresh reset
    to_drive();
    rst_n = 1'b0;
    to_drive();
    rst_n = 1'b1;
    a[0] = 32'd10; b[0] = 32'd1;
    a[1] = 32'd20; b[1] = 32'd2;
    a[2] = 32'd30; b[2] = 32'd3;
    req_valid = 3'b111;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("rr_grant", 64'(req_ready), 64'(exp_g[n]));
      after_edge();
      chk("rr_id", 64'(resp_id), 64'(n % 3));
      chk("rr_data", 64'(resp_data), 64'(11 * (n % 3 + 1)));
      to_drive();
    end
    req_valid = '0;

    // backpressure with req1 waiting
    to_drive();
    req_valid = 3'b001;
    after_edge();
    held = resp_data;
    chk("bp_load", 64'(held), 64'd11);
    to_drive();
    req_valid  = 3'b010;
    resp_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_data", 64'(resp_data), 64'd11);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      to_drive();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release", 64'(req_ready), 64'b010);
    after_edge();
    chk("bp_id", 64'(resp_id), 64'd1);
    chk("bp_sum", 64'(resp_data), 64'd22);
    to_drive();
    req_valid = '0;

    // wrap-around and overflow
    to_drive();
    a[2] = 32'hFFFF_FFFF;
    b[2] = 32'h0000_0001;
    req_valid = 3'b100;
    after_edge();
    chk("wrap_data", 64'(resp_data), 64'd0);
    chk("wrap_id", 64'(resp_id), 64'd2);
`ifdef ADDER_ARB_OVF_EN
    chk("wrap_ovf", 64'(resp_ovf), 64'd0);
    to_drive();
    a[2] = 32'h7FFF_FFFF;
    after_edge();
    chk("ovf_data", 64'(resp_data), 64'h8000_0000);
    chk("ovf_set", 64'(resp_ovf), 64'd1);
    to_drive();
    a[2] = 32'hFFFF_FFFF;
    after_edge();
    chk("ovf_clr", 64'(resp_ovf), 64'd0);
`endif
    to_drive();
    req_valid = '0;

    // asynchronous reset while a result is held
    to_drive();
    req_valid  = 3'b111;
    resp_ready = 1'b0;
    after_edge();
    chk("ar_pre", 64'(resp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(resp_valid), 64'd0);
    chk("ar_data", 64'(resp_data), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd0);
    to_drive();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("ar_tie", 64'(req_ready), 64'b001);
    after_edge();
    chk("ar_id", 64'(resp_id), 64'd0);
    chk("ar_sum", 64'(resp_data), 64'd11);
    to_drive();
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle", 64'(resp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
